ahb_mtx_input_stage: RTL and testbench

- Per-master input stage of the AHB bus matrix. It sits between one master-facing slave port and the address decoder, which drives the req_portN lines into the per-slave output arbiters.
- It registers an address phase that the target output stage cannot accept yet, then replays it to the decoder until it is granted.
- It generates HREADYOUTS/HRESPS back to the master.

---
 rtl/ahb_mtx_input_stage_if.sv | 47 ++++
 rtl/ahb_mtx_input_stage.sv | 122 ++++++++++++
 tb/tb_ahb_mtx_input_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/ahb_mtx_input_stage_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_mtx_input_stage_if : master-side AHB port plus decoder handshake lines
// Rev 1.0
// ----------------------------------------------------------------------------
interface ahb_mtx_input_stage_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  HSELS;
  logic [ADDR_WIDTH-1:0] HADDRS;
  logic [1:0]            HTRANSS;
  logic                  HWRITES;
  logic [2:0]            HSIZES;
  logic [2:0]            HBURSTS;
  logic [3:0]            HPROTS;
  logic                  HMASTLOCKS;
  logic                  HREADYS;
  logic                  HREADYOUTS;
  logic                  HRESPS;

  logic                  sel_dec;
  logic [ADDR_WIDTH-1:0] addr_dec;
  logic [1:0]            trans_dec;
  logic                  write_dec;
  logic [2:0]            size_dec;
  logic [2:0]            burst_dec;
  logic [3:0]            prot_dec;
  logic                  mastlock_dec;
  logic                  active_dec;
  logic                  readyout_dec;
  logic                  resp_dec;

  modport slave (
    input  HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, active_dec, readyout_dec, resp_dec,
    output HREADYOUTS, HRESPS, sel_dec, addr_dec, trans_dec, write_dec,
           size_dec, burst_dec, prot_dec, mastlock_dec
  );

  modport master (
    output HSELS, HADDRS, HTRANSS, HWRITES, HSIZES, HBURSTS, HPROTS,
           HMASTLOCKS, HREADYS, active_dec, readyout_dec, resp_dec,
    input  HREADYOUTS, HRESPS, sel_dec, addr_dec, trans_dec, write_dec,
           size_dec, burst_dec, prot_dec, mastlock_dec
  );
endinterface
`default_nettype wire

// File: rtl/ahb_mtx_input_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ahb_mtx_input_stage : per-master AHB matrix input stage (hold + replay)
// Rev 1.0
// ----------------------------------------------------------------------------
module ahb_mtx_input_stage #(
  parameter int ADDR_WIDTH = 32,
  parameter bit LOCK_HOLD  = 1'b1
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  ahb_mtx_input_stage_if.slave        bus
);

  logic                  w_trans_req;
  logic                  w_accept;

  logic                  pend_q, pend_d;
  logic                  dphase_q, dphase_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [1:0]            trans_q, trans_d;
  logic                  write_q, write_d;
  logic [2:0]            size_q, size_d;
  logic [2:0]            burst_q, burst_d;
  logic [3:0]            prot_q, prot_d;
  logic                  lock_q, lock_d;

  assign w_trans_req = bus.HSELS & bus.HREADYS & bus.HTRANSS[1];
  assign w_accept    = (w_trans_req | pend_q) & bus.active_dec;

  always_comb begin
    addr_d  = addr_q;
    trans_d = trans_q;
    write_d = write_q;
    size_d  = size_q;
    burst_d = burst_q;
    prot_d  = prot_q;
    lock_d  = lock_q;
    if (bus.HREADYS) begin
      addr_d  = bus.HADDRS;
      trans_d = bus.HTRANSS;
      write_d = bus.HWRITES;
      size_d  = bus.HSIZES;
      burst_d = bus.HBURSTS;
      prot_d  = bus.HPROTS;
      lock_d  = bus.HMASTLOCKS;
    end

    pend_d = pend_q;
    if (pend_q && bus.active_dec)
      pend_d = 1'b0;
    else if (w_trans_req && !bus.active_dec)
      pend_d = 1'b1;

    // A fresh acceptance wins over completion of the previous data phase.
    dphase_d = dphase_q;
    if (w_accept)
      dphase_d = 1'b1;
    else if (bus.readyout_dec)
      dphase_d = 1'b0;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      pend_q   <= 1'b0;
      dphase_q <= 1'b0;
      addr_q   <= '0;
      trans_q  <= '0;
      write_q  <= 1'b0;
      size_q   <= '0;
      burst_q  <= '0;
      prot_q   <= '0;
      lock_q   <= 1'b0;
    end else begin
      pend_q   <= pend_d;
      dphase_q <= dphase_d;
      addr_q   <= addr_d;
      trans_q  <= trans_d;
      write_q  <= write_d;
      size_q   <= size_d;
      burst_q  <= burst_d;
      prot_q   <= prot_d;
      lock_q   <= lock_d;
    end
  end

  always_comb begin
    if (pend_q) begin
      bus.sel_dec      = 1'b1;
      bus.addr_dec     = addr_q;
      bus.trans_dec    = trans_q;
      bus.write_dec    = write_q;
      bus.size_dec     = size_q;
      bus.burst_dec    = burst_q;
      bus.prot_dec     = prot_q;
      bus.mastlock_dec = lock_q & LOCK_HOLD;
    end else begin
      bus.sel_dec      = bus.HSELS & bus.HREADYS;
      bus.addr_dec     = bus.HADDRS;
      bus.trans_dec    = bus.HTRANSS;
      bus.write_dec    = bus.HWRITES;
      bus.size_dec     = bus.HSIZES;
      bus.burst_dec    = bus.HBURSTS;
      bus.prot_dec     = bus.HPROTS;
      bus.mastlock_dec = bus.HMASTLOCKS;
    end

    // The master is stalled in the data phase of a held transfer until granted.
    if (pend_q) begin
      bus.HREADYOUTS = 1'b0;
      bus.HRESPS     = 1'b0;
    end else if (dphase_q) begin
      bus.HREADYOUTS = bus.readyout_dec;
      bus.HRESPS     = bus.resp_dec;
    end else begin
      bus.HREADYOUTS = 1'b1;
      bus.HRESPS     = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_mtx_input_stage.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ahb_mtx_input_stage : directed scoreboard bench for the AHB input stage
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_ahb_mtx_input_stage;

  localparam logic [6:0] M_R  = 7'd1;
  localparam logic [6:0] M_P  = 7'd2;
  localparam logic [6:0] M_S  = 7'd4;
  localparam logic [6:0] M_A  = 7'd8;
  localparam logic [6:0] M_T  = 7'd16;
  localparam logic [6:0] M_L1 = 7'd32;
  localparam logic [6:0] M_L0 = 7'd64;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] BUSY   = 2'b01;
  localparam logic [1:0] NONSEQ = 2'b10;

  typedef struct {
    string       name;
    logic [6:0]  mask;
    logic        rdy;
    logic        resp;
    logic        sel;
    logic [31:0] addr;
    logic [1:0]  trans;
    logic        l1;
    logic        l0;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   n_total = 0;
  int   n_pass  = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ahb_mtx_input_stage_if #(.ADDR_WIDTH(32)) bus1 ();
  ahb_mtx_input_stage_if #(.ADDR_WIDTH(32)) bus0 ();

  ahb_mtx_input_stage #(.ADDR_WIDTH(32), .LOCK_HOLD(1'b1)) u_dut (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus1)
  );

  ahb_mtx_input_stage #(.ADDR_WIDTH(32), .LOCK_HOLD(1'b0)) u_dut_nl (
    .HCLK   (clk),
    .HRESET (rst),
    .bus    (bus0)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act !== req)
      $display("FAIL %s.%s actual=%0h required=%0h", nm, fld, act, req);
    else
      n_pass++;
  endtask

  // Monitor: mid-cycle, compare the DUT outputs against the next expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.mask[0]) chk(e.name, "HREADYOUTS", {31'd0, bus1.HREADYOUTS}, {31'd0, e.rdy});
      if (e.mask[1]) chk(e.name, "HRESPS", {31'd0, bus1.HRESPS}, {31'd0, e.resp});
      if (e.mask[2]) chk(e.name, "sel_dec", {31'd0, bus1.sel_dec}, {31'd0, e.sel});
      if (e.mask[3]) chk(e.name, "addr_dec", bus1.addr_dec, e.addr);
      if (e.mask[4]) chk(e.name, "trans_dec", {30'd0, bus1.trans_dec}, {30'd0, e.trans});
      if (e.mask[5]) chk(e.name, "mastlock_dec_hold1", {31'd0, bus1.mastlock_dec}, {31'd0, e.l1});
      if (e.mask[6]) chk(e.name, "mastlock_dec_hold0", {31'd0, bus0.mastlock_dec}, {31'd0, e.l0});
    end
  end

  task automatic step(input string nm, input logic r, input logic s, input logic [1:0] tr,
                      input logic [31:0] a, input logic w, input logic lk, input logic hr,
                      input logic act, input logic ro, input logic rp, input logic [6:0] m,
                      input logic e_rdy, input logic e_resp, input logic e_sel,
                      input logic [31:0] e_addr, input logic [1:0] e_tr,
                      input logic e_l1, input logic e_l0);
    exp_t e;
    rst = r;
    bus1.HSELS = s;        bus0.HSELS = s;
    bus1.HTRANSS = tr;     bus0.HTRANSS = tr;
    bus1.HADDRS = a;       bus0.HADDRS = a;
    bus1.HWRITES = w;      bus0.HWRITES = w;
    bus1.HSIZES = 3'd2;    bus0.HSIZES = 3'd2;
    bus1.HBURSTS = 3'd0;   bus0.HBURSTS = 3'd0;
    bus1.HPROTS = 4'd3;    bus0.HPROTS = 4'd3;
    bus1.HMASTLOCKS = lk;  bus0.HMASTLOCKS = lk;
    bus1.HREADYS = hr;     bus0.HREADYS = hr;
    bus1.active_dec = act; bus0.active_dec = act;
    bus1.readyout_dec = ro; bus0.readyout_dec = ro;
    bus1.resp_dec = rp;    bus0.resp_dec = rp;
    if (m != 7'd0) begin
      e.name = nm; e.mask = m; e.rdy = e_rdy; e.resp = e_resp; e.sel = e_sel;
      e.addr = e_addr; e.trans = e_tr; e.l1 = e_l1; e.l0 = e_l0;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    //   name      rst s  trans   addr          w  lk hr ac ro rp mask                      rdy rp sel addr          trans   l1 l0
    step("rst0",   1, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, 7'd0,                     0, 0, 0, 32'h0,        IDLE,   0, 0);
    step("rst1",   1, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, 7'd0,                     0, 0, 0, 32'h0,        IDLE,   0, 0);
    step("rst_st", 0, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, M_R|M_P|M_S|M_A,          1, 0, 0, 32'h0,        IDLE,   0, 0);
    // granted single write
    step("gr_ap",  0, 1, NONSEQ, 32'h2000_0010,1, 0, 1, 1, 1, 0, M_R|M_S|M_A|M_T,          1, 0, 1, 32'h2000_0010,NONSEQ, 0, 0);
    step("gr_dp",  0, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, M_R|M_P|M_S,              1, 0, 0, 32'h0,        IDLE,   0, 0);
    // slave inserts two wait states
    step("sw_ap",  0, 1, NONSEQ, 32'h3000_0000,0, 0, 1, 1, 1, 0, M_R|M_A,                  1, 0, 0, 32'h3000_0000,IDLE,   0, 0);
    step("sw_w1",  0, 0, IDLE,   32'h0,        0, 0, 0, 0, 0, 0, M_R|M_P,                  0, 0, 0, 32'h0,        IDLE,   0, 0);
    step("sw_w2",  0, 0, IDLE,   32'h0,        0, 0, 0, 0, 0, 0, M_R,                      0, 0, 0, 32'h0,        IDLE,   0, 0);
    step("sw_end", 0, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, M_R,                      1, 0, 0, 32'h0,        IDLE,   0, 0);
    // held transfer: not granted for 3 cycles
    step("hd_ap",  0, 1, NONSEQ, 32'h4000_0004,0, 0, 1, 0, 1, 0, M_R|M_S|M_A,              1, 0, 1, 32'h4000_0004,IDLE,   0, 0);
    step("hd_w1",  0, 1, NONSEQ, 32'hDEAD_BEEF,0, 0, 0, 0, 1, 0, M_R|M_S|M_A|M_T,          0, 0, 1, 32'h4000_0004,NONSEQ, 0, 0);
    step("hd_w2",  0, 1, NONSEQ, 32'hDEAD_BEEF,0, 0, 0, 0, 1, 0, M_R|M_A,                  0, 0, 0, 32'h4000_0004,IDLE,   0, 0);
    step("hd_gnt", 0, 1, NONSEQ, 32'hDEAD_BEEF,0, 0, 0, 1, 1, 0, M_R|M_S|M_A,              0, 0, 1, 32'h4000_0004,IDLE,   0, 0);
    step("hd_dp",  0, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, M_R|M_S,                  1, 0, 0, 32'h0,        IDLE,   0, 0);
    // two-cycle ERROR, master goes IDLE in the second cycle
    step("er_ap",  0, 1, NONSEQ, 32'h5000_0000,0, 0, 1, 1, 1, 0, M_R,                      1, 0, 0, 32'h0,        IDLE,   0, 0);
    step("er_c1",  0, 1, NONSEQ, 32'h5000_0004,0, 0, 0, 0, 0, 1, M_R|M_P,                  0, 1, 0, 32'h0,        IDLE,   0, 0);
    step("er_c2",  0, 1, IDLE,   32'h5000_0004,0, 0, 1, 0, 1, 1, M_R|M_P,                  1, 1, 0, 32'h0,        IDLE,   0, 0);
    step("busy",   0, 1, BUSY,   32'h5000_0008,0, 0, 1, 0, 1, 0, M_R|M_P|M_S|M_T,          1, 0, 1, 32'h0,        BUSY,   0, 0);
    step("nopend", 0, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, M_R|M_P|M_S,              1, 0, 0, 32'h0,        IDLE,   0, 0);
    // locked transfer held while pending
    step("lk_ap",  0, 1, NONSEQ, 32'h6000_0000,1, 1, 1, 0, 1, 0, M_S|M_L1|M_L0,            0, 0, 1, 32'h0,        IDLE,   1, 1);
    step("lk_w1",  0, 1, NONSEQ, 32'h6000_0004,1, 0, 0, 0, 1, 0, M_R|M_A|M_L1|M_L0,        0, 0, 0, 32'h6000_0000,IDLE,   1, 0);
    step("lk_gnt", 0, 1, NONSEQ, 32'h6000_0004,1, 0, 0, 1, 1, 0, M_R|M_S|M_L1|M_L0,        0, 0, 1, 32'h0,        IDLE,   1, 0);
    step("lk_dp",  0, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, M_R|M_L1|M_L0,            1, 0, 0, 32'h0,        IDLE,   0, 0);
    // reset while a transfer is pending
    step("mr_ap",  0, 1, NONSEQ, 32'h7000_0000,0, 0, 1, 0, 1, 0, M_R|M_S,                  1, 0, 1, 32'h0,        IDLE,   0, 0);
    step("mr_r1",  1, 1, NONSEQ, 32'h7000_0004,0, 0, 0, 0, 1, 0, M_R|M_S|M_A,              0, 0, 1, 32'h7000_0000,IDLE,   0, 0);
    step("mr_r2",  1, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, 7'd0,                     0, 0, 0, 32'h0,        IDLE,   0, 0);
    step("mr_post",0, 0, IDLE,   32'h0,        0, 0, 1, 0, 1, 0, M_R|M_P|M_S|M_A,          1, 0, 0, 32'h0,        IDLE,   0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    n_total++;
    if (exp_q.size() != 0)
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    else
      n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
